// File: rtl/obstacle_mask_loader.sv
// Fetches a packed obstacle bitmask from BRAM into a wide shift register and
// publishes it as one word once the collision phase is idle.
module obstacle_mask_loader #(
   parameter int WORD_W   = 32,
   parameter int IMG_BITS = 2500,
   parameter int N_WORDS  = 79,
   parameter int AW       = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [AW-1:0]       base_addr,
   input  logic                abort,
   input  logic                in_collision_state,
   output logic                bram_en,
   output logic [AW-1:0]       bram_addr,
   input  logic [WORD_W-1:0]   bram_dout,
   output logic [IMG_BITS-1:0] img_out,
   output logic                img_valid,
   output logic                busy
);

   localparam int CW = $clog2(N_WORDS + 1);
   localparam logic [CW-1:0] NW = CW'(N_WORDS);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_PHASE} state_t;

   state_t              state;
   logic [AW-1:0]       base_l;
   logic [CW-1:0]       issue_cnt;
   logic [CW-1:0]       cap_cnt;
   logic                en_d;
   logic [IMG_BITS-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base_l    <= '0;
         issue_cnt <= '0;
         cap_cnt   <= '0;
         en_d      <= 1'b0;
         shreg     <= '0;
         bram_en   <= 1'b0;
         bram_addr <= '0;
         img_out   <= '0;
         img_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         img_valid <= 1'b0;
         en_d      <= bram_en;
         // BRAM data lags the enable by one cycle; word 0 ends up in the MSBs
         if (en_d) begin
            shreg   <= {shreg[IMG_BITS-WORD_W-1:0], bram_dout};
            cap_cnt <= cap_cnt + 1'b1;
         end
         if (abort && state != IDLE) begin
            state   <= IDLE;
            bram_en <= 1'b0;
            busy    <= 1'b0;
            en_d    <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  base_l    <= base_addr;
                  bram_en   <= 1'b1;
                  bram_addr <= base_addr;
                  issue_cnt <= CW'(1);
                  cap_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
               FETCH: if (issue_cnt == NW) begin
                  bram_en <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  bram_addr <= base_l + AW'(issue_cnt);
                  issue_cnt <= issue_cnt + 1'b1;
               end
               DRAIN: state <= WAIT_PHASE;
               WAIT_PHASE: if (cap_cnt == NW && !in_collision_state) begin
                  img_out   <= shreg;
                  img_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_obstacle_mask_loader.sv
// Directed and randomized loads checked against a word-placement model of the mask.
module tb_obstacle_mask_loader;
   localparam int WORD_W = 32, IMG_BITS = 2500, N_WORDS = 79, AW = 10;

   logic clk = 0, rst = 1, start = 0, abort = 0, in_collision_state = 0;
   logic [AW-1:0] base_addr = '0;
   logic bram_en, img_valid, busy;
   logic [AW-1:0] bram_addr;
   logic [WORD_W-1:0] bram_dout = '0;
   logic [IMG_BITS-1:0] img_out;

   logic [WORD_W-1:0] mem [0:1023];
   logic [IMG_BITS-1:0] exp_img;
   int tests = 0, fails = 0;

   obstacle_mask_loader #(.WORD_W(WORD_W), .IMG_BITS(IMG_BITS), .N_WORDS(N_WORDS), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
      .in_collision_state(in_collision_state), .bram_en(bram_en), .bram_addr(bram_addr),
      .bram_dout(bram_dout), .img_out(img_out), .img_valid(img_valid), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

   function automatic logic [IMG_BITS-1:0] model(input int base);
      logic [N_WORDS*WORD_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < N_WORDS; k++)
         acc[(N_WORDS-1-k)*WORD_W +: WORD_W] = mem[(base + k) % 1024];
      return acc[IMG_BITS-1:0];
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_img(input string tag, input logic [IMG_BITS-1:0] expv);
      tests++;
      assert (img_out === expv) else begin
         fails++;
         $error("FAIL %s img_out[63:0]=%h expected[63:0]=%h", tag, img_out[63:0], expv[63:0]);
      end
   endtask

   // t counts edges since the start-sampling edge E0
   task automatic load(input int base, input int hold, input int pulse_k, input int abort_k, input int rst_t);
      logic [IMG_BITS-1:0] new_img;
      int t;
      logic seen;
      new_img = model(base);
      base_addr = AW'(base);
      in_collision_state = (hold > 0);
      start = 1;
      step();
      start = 0;
      t = 0;
      for (int k = 0; k < N_WORDS; k++) begin
         start = (k == pulse_k);
         chk("fetch_en", bram_en, 1);
         chk("fetch_addr", bram_addr, (base + k) % 1024);
         if (k == abort_k) begin
            abort = 1;
            step();
            abort = 0;
            chk("abort_en", bram_en, 0);
            chk("abort_busy", busy, 0);
            seen = 0;
            for (int i = 0; i < 100; i++) begin
               seen |= img_valid;
               step();
            end
            chk("abort_no_valid", seen, 0);
            chk_img("abort_img_kept", exp_img);
            return;
         end
         step();
         t++;
      end
      start = 0;
      chk("drain_en", bram_en, 0);
      while (!img_valid && t < 400) begin
         chk("wait_busy", busy, 1);
         chk_img("wait_img_held", exp_img);
         if (t == rst_t) begin
            #1 rst = 1;
            #1;
            chk("rst_img_valid", img_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_en", bram_en, 0);
            chk("rst_addr", bram_addr, 0);
            chk_img("rst_img", '0);
            rst = 0;
            in_collision_state = 0;
            exp_img = '0;
            step();
            return;
         end
         if (hold > 0 && t == 80 + hold) in_collision_state = 0;
         step();
         t++;
      end
      chk("latency", t, 81 + hold);
      chk("commit_busy", busy, 0);
      chk_img("commit_img", new_img);
      exp_img = new_img;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         seen |= img_valid | busy;
      end
      chk("single_pulse", seen, 0);
   endtask

   initial begin
      exp_img = '0;
      for (int a = 0; a < 1024; a++) mem[a] = WORD_W'(a + 1);
      #1;
      chk("reset_en", bram_en, 0);
      chk("reset_addr", bram_addr, 0);
      chk("reset_valid", img_valid, 0);
      chk("reset_busy", busy, 0);
      chk_img("reset_img", '0);
      step(); step();
      rst = 0;
      step();

      load(0, 0, -1, -1, -1);
      chk("word78", img_out[31:0], 79);
      chk("word77", img_out[63:32], 78);
      chk("word0_top", img_out[2499:2496], 4'h1);

      load(0, 20, -1, -1, -1);
      load(1000, 0, -1, -1, -1);
      load(0, 0, -1, 40, -1);
      load(0, 0, -1, -1, -1);
      load(5, 0, 10, -1, -1);
      load(7, 20, -1, -1, 90);
      load(3, 0, -1, -1, -1);

      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 1024; a++) mem[a] = $urandom;
         load(int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)), -1, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
